// File: rtl/e203_tb_irq_pkg.sv
// e203_tb_irq_pkg: shared types, default PCs and LFSR helpers for the interrupt injector
package e203_tb_irq_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ASSERT, DONE} chan_st_e;
  localparam logic [31:0] DEF_ARM_PC    = 32'h8000015C;
  localparam logic [31:0] DEF_TOHOST_PC = 32'h80000086;
  localparam logic [31:0] DEF_EXT_ACK   = 32'h800000A6;
  localparam logic [31:0] DEF_SFT_ACK   = 32'h800000BE;
  localparam logic [31:0] DEF_TMR_ACK   = 32'h800000D6;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  // An all-zero LFSR would lock up, so a zero seed is replaced.
  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'h0) ? 16'h0001 : s;
  endfunction
endpackage

// File: rtl/e203_irq_inj_chan.sv
// e203_irq_inj_chan: one interrupt channel with LFSR gap, gap counter, FSM and ack counter
module e203_irq_inj_chan
  import e203_tb_irq_pkg::*;
#(
  parameter int unsigned        PC_W   = 32,
  parameter logic [PC_W-1:0]    ACK_PC = DEF_EXT_ACK,
  parameter logic [15:0]        SEED   = 16'hACE1,
  parameter int unsigned        GAP_W  = 10
) (
  input  logic            hfclk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            armed,
  input  logic            stopped,
  input  logic            cmt_valid,
  input  logic [PC_W-1:0] cmt_pc,
  output logic            irq,
  output logic [15:0]     inj_cnt
);
  localparam logic [15:0] SEED_FIX = fix_seed(SEED);
  chan_st_e         st_q, st_d;
  logic [GAP_W:0]   cnt_q, cnt_d, gap;
  logic [15:0]      lfsr_q, lfsr_d, inj_cnt_q, inj_cnt_d;
  logic             hit, load;
  always_comb begin
    hit       = cmt_valid & (cmt_pc == ACK_PC);
    gap       = {1'b0, lfsr_q[GAP_W-1:0]} + (GAP_W+1)'(1);
    st_d      = st_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    inj_cnt_d = inj_cnt_q;
    load      = 1'b0;
    if (st_q != DONE && !en) st_d = IDLE;
    else case (st_q)
      IDLE: load = armed & ~stopped;
      WAIT: begin
        if (stopped) st_d = DONE;
        else if (cnt_q == (GAP_W+1)'(1)) st_d = ASSERT;
        else cnt_d = cnt_q - (GAP_W+1)'(1);
      end
      ASSERT: if (hit) begin
        inj_cnt_d = inj_cnt_q + {15'b0, inj_cnt_q != 16'hFFFF};
        if (stopped) st_d = DONE;
        else load = 1'b1;
      end
      default: ;
    endcase
    // Gap uses the pre-advance LFSR value; the LFSR steps once per load.
    if (load) begin
      st_d   = WAIT;
      cnt_d  = gap;
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
    end
  end
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= SEED_FIX;
      inj_cnt_q <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      inj_cnt_q <= inj_cnt_d;
    end
  end
  assign irq     = (st_q == ASSERT);
  assign inj_cnt = inj_cnt_q;
endmodule

// File: rtl/e203_irq_injector.sv
// e203_irq_injector: pseudo-random ext/sft/tmr interrupt stimulus driven by the commit stream
module e203_irq_injector
  import e203_tb_irq_pkg::*;
#(
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] ARM_PC     = DEF_ARM_PC,
  parameter logic [PC_W-1:0] TOHOST_PC  = DEF_TOHOST_PC,
  parameter logic [PC_W-1:0] EXT_ACK_PC = DEF_EXT_ACK,
  parameter logic [PC_W-1:0] SFT_ACK_PC = DEF_SFT_ACK,
  parameter logic [PC_W-1:0] TMR_ACK_PC = DEF_TMR_ACK,
  parameter logic [31:0]     STOP_CNT   = 32,
  parameter int unsigned     GAP_W      = 10,
  parameter logic [15:0]     SEED_EXT   = 16'hACE1,
  parameter logic [15:0]     SEED_SFT   = 16'h1D2B,
  parameter logic [15:0]     SEED_TMR   = 16'h7F31
) (
  input  logic            hfclk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            cmt_valid,
  input  logic [PC_W-1:0] cmt_pc,
  output logic            ext_irq,
  output logic            sft_irq,
  output logic            tmr_irq,
  output logic            armed,
  output logic            stopped,
  output logic [31:0]     tohost_cnt,
  output logic [15:0]     inj_cnt_ext,
  output logic [15:0]     inj_cnt_sft,
  output logic [15:0]     inj_cnt_tmr
);
  logic        armed_q, armed_d, stopped_q, stopped_d, arm_hit, toh_hit;
  logic [31:0] tohost_cnt_q, tohost_cnt_d;
  always_comb begin
    arm_hit      = cmt_valid & (cmt_pc == ARM_PC);
    toh_hit      = cmt_valid & (cmt_pc == TOHOST_PC);
    armed_d      = armed_q | arm_hit;
    tohost_cnt_d = tohost_cnt_q + {31'b0, toh_hit & (tohost_cnt_q != 32'hFFFF_FFFF)};
    stopped_d    = tohost_cnt_q > STOP_CNT;
  end
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q      <= 1'b0;
      stopped_q    <= 1'b0;
      tohost_cnt_q <= '0;
    end else begin
      armed_q      <= armed_d;
      stopped_q    <= stopped_d;
      tohost_cnt_q <= tohost_cnt_d;
    end
  end
  assign armed      = armed_q;
  assign stopped    = stopped_q;
  assign tohost_cnt = tohost_cnt_q;
  e203_irq_inj_chan #(.PC_W(PC_W), .ACK_PC(EXT_ACK_PC), .SEED(SEED_EXT), .GAP_W(GAP_W)) u_ext (
    .hfclk(hfclk), .rst_n(rst_n), .en(en), .armed(armed_q), .stopped(stopped_q),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .irq(ext_irq), .inj_cnt(inj_cnt_ext));
  e203_irq_inj_chan #(.PC_W(PC_W), .ACK_PC(SFT_ACK_PC), .SEED(SEED_SFT), .GAP_W(GAP_W)) u_sft (
    .hfclk(hfclk), .rst_n(rst_n), .en(en), .armed(armed_q), .stopped(stopped_q),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .irq(sft_irq), .inj_cnt(inj_cnt_sft));
  e203_irq_inj_chan #(.PC_W(PC_W), .ACK_PC(TMR_ACK_PC), .SEED(SEED_TMR), .GAP_W(GAP_W)) u_tmr (
    .hfclk(hfclk), .rst_n(rst_n), .en(en), .armed(armed_q), .stopped(stopped_q),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .irq(tmr_irq), .inj_cnt(inj_cnt_tmr));
endmodule

// File: tb/tb_e203_irq_injector.sv
// tb_e203_irq_injector: directed tables plus cycle scoreboard against a reference model
module tb_e203_irq_injector;
  localparam int          GAP_W = 4;
  localparam logic [31:0] STOP  = 32;
  localparam logic [31:0] ARM   = 32'h8000015C;
  localparam logic [31:0] TOH   = 32'h80000086;
  localparam logic [31:0] ACKS [3] = '{32'h800000A6, 32'h800000BE, 32'h800000D6};
  localparam logic [15:0] SEEDS[3] = '{16'h0001, 16'h1D2B, 16'h7F31};

  logic        hfclk = 1'b0, rst_n = 1'b0, en = 1'b0, cmt_valid = 1'b0;
  logic [31:0] cmt_pc = '0;
  logic        ext_irq, sft_irq, tmr_irq, armed, stopped;
  logic [31:0] tohost_cnt;
  logic [15:0] inj_cnt_ext, inj_cnt_sft, inj_cnt_tmr;

  e203_irq_injector #(.STOP_CNT(STOP), .GAP_W(GAP_W), .SEED_EXT(16'h0001)) dut (
    .hfclk(hfclk), .rst_n(rst_n), .en(en), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .ext_irq(ext_irq), .sft_irq(sft_irq), .tmr_irq(tmr_irq), .armed(armed), .stopped(stopped),
    .tohost_cnt(tohost_cnt), .inj_cnt_ext(inj_cnt_ext), .inj_cnt_sft(inj_cnt_sft),
    .inj_cnt_tmr(inj_cnt_tmr));

  always #5 hfclk = ~hfclk;

  typedef struct {
    logic        en, vld;
    logic [31:0] pc;
    logic        exp_armed, exp_ext, exp_tmr;
    logic [15:0] exp_inj;
  } vec_t;
  vec_t tbl[22];

  int n_chk = 0, n_fail = 0, cyc_n = 0;
  logic [84:0] sb_q[$];

  // Reference model state: 0 IDLE, 1 WAIT, 2 ASSERT, 3 DONE
  int          m_st[3], m_cnt[3];
  logic [15:0] m_lfsr[3], m_inj[3];
  logic        m_armed, m_stopped;
  logic [31:0] m_toh;

  function automatic logic [15:0] adv(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_st[c] = 0; m_cnt[c] = 0; m_lfsr[c] = SEEDS[c]; m_inj[c] = '0;
    end
    m_armed = 1'b0; m_stopped = 1'b0; m_toh = '0;
  endtask

  task automatic model_step(input logic e, input logic v, input logic [31:0] p);
    logic a, s;
    a = m_armed; s = m_stopped;
    for (int c = 0; c < 3; c++) begin
      logic ld;
      ld = 1'b0;
      if (m_st[c] == 3) ;
      else if (!e) m_st[c] = 0;
      else if (m_st[c] == 0) ld = a && !s;
      else if (m_st[c] == 1) begin
        if (s) m_st[c] = 3;
        else if (m_cnt[c] == 1) m_st[c] = 2;
        else m_cnt[c]--;
      end else if (v && p == ACKS[c]) begin
        if (m_inj[c] != 16'hFFFF) m_inj[c]++;
        if (s) m_st[c] = 3; else ld = 1'b1;
      end
      if (ld) begin
        m_cnt[c]  = int'(m_lfsr[c][GAP_W-1:0]) + 1;
        m_lfsr[c] = adv(m_lfsr[c]);
        m_st[c]   = 1;
      end
    end
    if (v && p == ARM) m_armed = 1'b1;
    m_stopped = m_toh > STOP;
    if (v && p == TOH && m_toh != 32'hFFFF_FFFF) m_toh++;
  endtask

  function automatic logic [84:0] model_vec();
    return {m_st[0] == 2, m_st[1] == 2, m_st[2] == 2, m_armed, m_stopped, m_toh,
            m_inj[0], m_inj[1], m_inj[2]};
  endfunction

  function automatic logic [84:0] dut_vec();
    return {ext_irq, sft_irq, tmr_irq, armed, stopped, tohost_cnt,
            inj_cnt_ext, inj_cnt_sft, inj_cnt_tmr};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc_n, got, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic v, input logic [31:0] p);
    logic [84:0] exp;
    en = e; cmt_valid = v; cmt_pc = p;
    model_step(e, v, p);
    sb_q.push_back(model_vec());
    @(posedge hfclk); #1;
    cyc_n++;
    exp = sb_q.pop_front();
    n_chk++;
    if (dut_vec() !== exp) begin
      n_fail++;
      $display("FAIL scoreboard cyc=%0d got=%h exp=%h", cyc_n, dut_vec(), exp);
    end
  endtask

  task automatic run_table(input string tag);
    for (int k = 0; k < 22; k++) begin
      chk({tag, "_armed"}, 32'(armed), 32'(tbl[k].exp_armed));
      chk({tag, "_ext"}, 32'(ext_irq), 32'(tbl[k].exp_ext));
      chk({tag, "_tmr"}, 32'(tmr_irq), 32'(tbl[k].exp_tmr));
      chk({tag, "_inj_ext"}, 32'(inj_cnt_ext), 32'(tbl[k].exp_inj));
      cyc(tbl[k].en, tbl[k].vld, tbl[k].pc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_irqs"}, 32'({ext_irq, sft_irq, tmr_irq}), 32'd0);
    chk({tag, "_armed"}, 32'(armed), 32'd0);
    chk({tag, "_stopped"}, 32'(stopped), 32'd0);
    chk({tag, "_tohost"}, tohost_cnt, 32'd0);
    chk({tag, "_inj"}, 32'(inj_cnt_ext | inj_cnt_sft | inj_cnt_tmr), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    logic any_irq;
    // ext seed 1 -> gap 2, tmr seed 7F31 -> gap 2: both rise 4 cycles after the ARM hit
    for (int k = 0; k < 22; k++)
      tbl[k] = '{1'b1, 1'b0, 32'h0, k >= 11, (k >= 14 && k <= 20), k >= 14,
                 (k >= 21) ? 16'd1 : 16'd0};
    tbl[10].vld = 1'b1; tbl[10].pc = ARM;
    tbl[20].vld = 1'b1; tbl[20].pc = ACKS[0];

    model_reset();
    repeat (3) @(posedge hfclk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    run_table("arm1");

    // ext re-asserted after a gap of 1; reset in the middle of ASSERT
    chk("pre_rst_ext", 32'(ext_irq), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(posedge hfclk); #1;
    rst_n = 1'b1;
    cyc_n = 0;
    run_table("arm2");

    // en drop during ASSERT
    cyc(1'b0, 1'b0, 32'h0);
    chk("en_drop_assert_ext", 32'(ext_irq), 32'd0);
    chk("en_drop_assert_inj", 32'(inj_cnt_ext), 32'd1);
    cyc(1'b1, 1'b0, 32'h0);
    // ext is now in WAIT with gap 1; dropping en must suppress the rise
    cyc(1'b0, 1'b0, 32'h0);
    chk("en_drop_wait_ext", 32'(ext_irq), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("en_drop_wait_ext2", 32'(ext_irq), 32'd0);
    w = 0;
    while (!ext_irq && w < 40) begin cyc(1'b1, 1'b0, 32'h0); w++; end
    chk("en_restart_rise", 32'(ext_irq), 32'd1);
    chk("en_restart_inj", 32'(inj_cnt_ext), 32'd1);

    for (int i = 0; i < 4000; i++) begin
      logic [31:0] p;
      int r;
      r = $urandom_range(7);
      p = (r < 3) ? ACKS[r] : (r == 3) ? ARM : $urandom;
      if (p == TOH) p = 32'h0;
      cyc($urandom_range(63) != 0, $urandom_range(1) == 1, p);
    end

    w = 0;
    while (!tmr_irq && w < 200) begin cyc(1'b1, 1'b0, 32'h0); w++; end
    chk("tmr_up_before_stop", 32'(tmr_irq), 32'd1);
    for (int i = 0; i < 33; i++) cyc(1'b1, 1'b1, TOH);
    chk("stop_latency_pre", 32'(stopped), 32'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("stopped", 32'(stopped), 32'd1);
    chk("tohost_cnt", tohost_cnt, 32'd33);
    chk("tmr_held_after_stop", 32'(tmr_irq), 32'd1);
    cyc(1'b1, 1'b1, ACKS[2]);
    chk("tmr_ack_after_stop", 32'(tmr_irq), 32'd0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, ACKS[i % 2]);
    any_irq = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 1'b1, ACKS[2]);
      any_irq |= ext_irq | sft_irq | tmr_irq;
    end
    chk("no_irq_after_done", 32'(any_irq), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
